// File: rtl/classifier_sequencer_if.sv
// rtl/classifier_sequencer_if.sv - handshake, result and readback signals of the classifier sequencer
interface classifier_sequencer_if;
   logic        start;
   logic        done_row;
   logic [15:0] row_result;
   logic        overflow;
   logic        begin_mult;
   logic [3:0]  row_select;
   logic        busy;
   logic        done;
   logic [3:0]  class_idx;
   logic [15:0] class_score;
   logic        ovf_any;
   logic        err_timeout;
   logic [3:0]  rd_sel;
   logic [15:0] rd_score;

   modport master (
      input  start, done_row, row_result, overflow, rd_sel,
      output begin_mult, row_select, busy, done, class_idx, class_score,
             ovf_any, err_timeout, rd_score
   );

   modport slave (
      output start, done_row, row_result, overflow, rd_sel,
      input  begin_mult, row_select, busy, done, class_idx, class_score,
             ovf_any, err_timeout, rd_score
   );
endinterface

// File: rtl/classifier_sequencer.sv
// rtl/classifier_sequencer.sv - issues one multiplier row per class, saturates scores, tracks argmax
module classifier_sequencer #(
   parameter int NUM_ROWS = 10,
   parameter int TIMEOUT  = 1024
) (
   input logic                   clk,
   input logic                   rst,
   classifier_sequencer_if.master bus
);
   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_NEXT   = 3'd3,
      S_FINISH = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [3:0]         row_q, row_d;
   logic [WD_W-1:0]    wd_q, wd_d;
   logic signed [15:0] best_q, best_d;
   logic [3:0]         best_idx_q, best_idx_d;
   logic [3:0]         class_idx_q, class_idx_d;
   logic [15:0]        class_score_q, class_score_d;
   logic               ovf_q, ovf_d;
   logic               err_q, err_d;
   logic               cap_en;
   logic signed [15:0] score_s;
   logic [15:0]        score_buf_q [16];

   // The sign bit of a wrapped sum is inverted, so it tells which rail to clamp to.
   always_comb begin
      score_s = bus.row_result;
      if (bus.overflow) begin
         score_s = bus.row_result[15] ? 16'sh7FFF : 16'sh8000;
      end
   end

   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      wd_d          = wd_q;
      best_d        = best_q;
      best_idx_d    = best_idx_q;
      class_idx_d   = class_idx_q;
      class_score_d = class_score_q;
      ovf_d         = ovf_q;
      err_d         = err_q;
      cap_en        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_ISSUE;
               ovf_d      = 1'b0;
               err_d      = 1'b0;
               best_idx_d = 4'd0;
               best_d     = 16'sh8000;
               row_d      = 4'd0;
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            wd_d = wd_q + 1'b1;
            if (bus.done_row) begin
               cap_en  = 1'b1;
               state_d = S_NEXT;
               if (bus.overflow) begin
                  ovf_d = 1'b1;
               end
               if (score_s > best_q) begin
                  best_d     = score_s;
                  best_idx_d = row_q;
               end
            end else if (wd_d == WD_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_NEXT: begin
            if (row_q == 4'(NUM_ROWS - 1)) begin
               state_d = S_FINISH;
            end else begin
               row_d   = row_q + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Both paths into FINISH leave best untouched in that cycle, so the registered copy is final.
      if (state_d == S_FINISH && state_q != S_FINISH) begin
         class_idx_d   = best_idx_q;
         class_score_d = best_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         row_q         <= 4'd0;
         wd_q          <= '0;
         best_q        <= 16'sh0;
         best_idx_q    <= 4'd0;
         class_idx_q   <= 4'd0;
         class_score_q <= 16'h0;
         ovf_q         <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         wd_q          <= wd_d;
         best_q        <= best_d;
         best_idx_q    <= best_idx_d;
         class_idx_q   <= class_idx_d;
         class_score_q <= class_score_d;
         ovf_q         <= ovf_d;
         err_q         <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            score_buf_q[i] <= 16'h0;
         end
      end else if (cap_en) begin
         score_buf_q[row_q] <= score_s;
      end
   end

   assign bus.begin_mult  = (state_q == S_ISSUE);
   assign bus.done        = (state_q == S_FINISH);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.row_select  = row_q;
   assign bus.class_idx   = class_idx_q;
   assign bus.class_score = class_score_q;
   assign bus.ovf_any     = ovf_q;
   assign bus.err_timeout = err_q;
   assign bus.rd_score    = ({1'b0, bus.rd_sel} < 5'(NUM_ROWS)) ? score_buf_q[bus.rd_sel] : 16'h0;
endmodule
